// File: rtl/tpm_round_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tpm_round_sequencer_if
//  Description : Control/handshake bundle between key-exchange control, the
//                round sequencer and the MAC/weight datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tpm_round_sequencer_if #(
  parameter int CW = 5,
  parameter int UW = 2,
  parameter int SW = 8
);
  logic          start;
  logic          tau_valid;
  logic          tau_ours;
  logic          tau_part;
  logic          busy;
  logic [UW-1:0] unit;
  logic [CW-1:0] idx;
  logic          clr_acc;
  logic          mac_en;
  logic          eval;
  logic          upd_en;
  logic          done;
  logic          match;
  logic          timeout;
  logic [SW-1:0] sync_cnt;
  logic          synced;

  // Control side: requests rounds, supplies tau bits, observes sequencing.
  modport master (
    output start, tau_valid, tau_ours, tau_part,
    input  busy, unit, idx, clr_acc, mac_en, eval, upd_en, done,
           match, timeout, sync_cnt, synced
  );

  // Sequencer side.
  modport slave (
    input  start, tau_valid, tau_ours, tau_part,
    output busy, unit, idx, clr_acc, mac_en, eval, upd_en, done,
           match, timeout, sync_cnt, synced
  );
endinterface
`default_nettype wire

// File: rtl/tpm_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tpm_round_sequencer
//  Description : Sequences one tree-parity-machine round: K x N accumulate
//                sweep, evaluate, wait for partner bit, weight update on a
//                match. Tracks consecutive matched rounds and flags sync.
//  Revision    : 1.0 - initial release
// ============================================================================
module tpm_round_sequencer #(
  parameter int K       = 3,
  parameter int N       = 20,
  parameter int CW      = 5,
  parameter int UW      = 2,
  parameter int TMO     = 16,
  parameter int SYNC_TH = 4,
  parameter int SW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  tpm_round_sequencer_if.slave  bus
);

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_UPD  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [CW-1:0] IDX_LAST  = CW'(N - 1);
  localparam logic [UW-1:0] UNIT_LAST = UW'(K - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(TMO - 1);
  localparam logic [SW-1:0] SYNC_MAX  = {SW{1'b1}};
  localparam logic [SW-1:0] SYNC_THR  = SW'(SYNC_TH);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [UW-1:0] unit_q;
  logic [CW-1:0] idx_q;
  logic [TW-1:0] timer;
  logic          match_q;
  logic          timeout_q;
  logic [SW-1:0] sync_q;

  logic idx_wrap;
  logic last_unit;
  logic tau_eq;
  logic tmr_expired;
  logic match_new;

  assign idx_wrap    = (idx_q == IDX_LAST);
  assign last_unit   = (unit_q == UNIT_LAST);
  assign tau_eq      = (bus.tau_ours == bus.tau_part);
  assign tmr_expired = (timer == TMR_LAST);
  // Match outcome as it will stand once the current cycle commits; only a
  // valid, equal partner bit in WAIT_P can make a fresh match.
  assign match_new   = (state == S_WAIT) ? (bus.tau_valid & tau_eq) : match_q;

  // State register; reset aborts any round in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode for the round phases.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_CLR;
      S_CLR:  state_nxt = S_MAC;
      S_MAC:  if (idx_wrap) state_nxt = last_unit ? S_EVAL : S_CLR;
      S_EVAL: state_nxt = S_WAIT;
      S_WAIT: begin
        // A valid partner bit takes priority over an expiring timer.
        if (bus.tau_valid)    state_nxt = tau_eq ? S_UPD : S_DONE;
        else if (tmr_expired) state_nxt = S_DONE;
      end
      S_UPD:  if (idx_wrap && last_unit) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Unit/index sweep; values hold outside the sweeping phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_q <= '0;
      idx_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            unit_q <= '0;
            idx_q  <= '0;
          end
        end
        S_MAC, S_UPD: begin
          if (idx_wrap) begin
            // The final wrap leaves unit/idx at their last position.
            if (!last_unit) begin
              idx_q  <= '0;
              unit_q <= unit_q + UW'(1);
            end
          end else begin
            idx_q <= idx_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (bus.tau_valid && tau_eq) begin
            unit_q <= '0;
            idx_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Partner-wait timer, cleared in EVAL and counting idle WAIT_P cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state == S_EVAL) begin
      timer <= '0;
    end else if (state == S_WAIT && !bus.tau_valid && !tmr_expired) begin
      timer <= timer + TW'(1);
    end
  end

  // Round result flags, held until the next round resolves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else if (state == S_WAIT) begin
      if (bus.tau_valid) begin
        match_q   <= tau_eq;
        timeout_q <= 1'b0;
      end else if (tmr_expired) begin
        match_q   <= 1'b0;
        timeout_q <= 1'b1;
      end
    end
  end

  // Consecutive-match counter, updated on entry to DONE, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else if (state_nxt == S_DONE && state != S_DONE) begin
      if (!match_new)               sync_q <= '0;
      else if (sync_q != SYNC_MAX)  sync_q <= sync_q + SW'(1);
    end
  end

  // Output decode: strobes from state, status from registers.
  always_comb begin
    bus.busy     = (state != S_IDLE);
    bus.clr_acc  = (state == S_CLR);
    bus.mac_en   = (state == S_MAC);
    bus.eval     = (state == S_EVAL);
    bus.upd_en   = (state == S_UPD);
    bus.done     = (state == S_DONE);
    bus.unit     = unit_q;
    bus.idx      = idx_q;
    bus.match    = match_q;
    bus.timeout  = timeout_q;
    bus.sync_cnt = sync_q;
    bus.synced   = (sync_q >= SYNC_THR);
  end

endmodule
`default_nettype wire

// File: tb/tb_tpm_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tpm_round_sequencer
//  Description : Self-checking bench: directed round table, reset abort,
//                and randomized rounds against a round-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tpm_round_sequencer;

  localparam int K = 3, N = 20, CW = 5, UW = 2, TMO = 16, SYNC_TH = 4, SW = 8;
  localparam int SYNC_SAT = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tpm_round_sequencer_if #(.CW(CW), .UW(UW), .SW(SW)) bus ();

  tpm_round_sequencer #(
    .K(K), .N(N), .CW(CW), .UW(UW), .TMO(TMO), .SYNC_TH(SYNC_TH), .SW(SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  typedef struct {
    int vcyc;      // WAIT_P cycle carrying tau_valid (0 = never)
    bit ours;
    bit part;
    bit noise;     // pulse start/tau_valid during MAC
    int exp_lat;   // cycle of done, cycle 1 = first CLR cycle
    bit exp_m;
    bit exp_t;
    int exp_sync;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int ref_sync = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int all_outputs();
    return int'({bus.busy, bus.unit, bus.idx, bus.clr_acc, bus.mac_en, bus.eval,
                 bus.upd_en, bus.done, bus.match, bus.timeout, bus.sync_cnt, bus.synced});
  endfunction

  // Round-level reference: outcome and latency from the phase arithmetic.
  task automatic model_round(input int vcyc, input bit o, input bit p,
                             output int lat, output bit m, output bit t);
    bit hit;
    int w;
    hit = (vcyc >= 1) && (vcyc <= TMO);
    m   = hit && (o == p);
    t   = !hit;
    w   = hit ? vcyc : TMO;
    lat = K * (N + 1) + 1 + w + (m ? K * N : 0) + 1;
  endtask

  task automatic run_round(input int r, input vec_t v);
    int  cyc, n_clr, n_mac, n_eval, n_upd, order_err, lat, wp;
    int  d_m, d_t, d_sync, d_synced;
    bit  got_done, in_wait, prev_eval;
    cyc = 1; n_clr = 0; n_mac = 0; n_eval = 0; n_upd = 0; order_err = 0;
    lat = -1; wp = 0; got_done = 0; in_wait = 0; prev_eval = 0;
    d_m = -1; d_t = -1; d_sync = -1; d_synced = -1;

    @(negedge clk);
    bus.start = 1'b1; bus.tau_ours = v.ours; bus.tau_part = v.part; bus.tau_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;

    while (!got_done && cyc <= 400) begin
      if (bus.clr_acc) n_clr++;
      if (bus.eval)    n_eval++;
      if (bus.mac_en) begin
        if (int'(bus.unit) != n_mac / N || int'(bus.idx) != n_mac % N) order_err++;
        n_mac++;
      end
      if (bus.upd_en) begin
        if (int'(bus.unit) != n_upd / N || int'(bus.idx) != n_upd % N) order_err++;
        n_upd++;
      end
      if (prev_eval) begin in_wait = 1; wp = 0; end
      if (bus.upd_en || bus.done) in_wait = 0;
      if (in_wait) wp++;
      prev_eval = bus.eval;
      if (bus.done) begin
        got_done = 1; lat = cyc;
        d_m = int'(bus.match); d_t = int'(bus.timeout);
        d_sync = int'(bus.sync_cnt); d_synced = int'(bus.synced);
      end else begin
        bus.tau_valid = (in_wait && wp == v.vcyc) || (v.noise && bus.mac_en && n_mac == 6);
        bus.start     = v.noise && bus.mac_en && n_mac == 6;
        @(negedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0; bus.tau_valid = 1'b0;

    check($sformatf("r%0d_latency", r), lat, v.exp_lat);
    check($sformatf("r%0d_clr_pulses", r), n_clr, K);
    check($sformatf("r%0d_mac_cycles", r), n_mac, K * N);
    check($sformatf("r%0d_eval_pulses", r), n_eval, 1);
    check($sformatf("r%0d_upd_cycles", r), n_upd, v.exp_m ? K * N : 0);
    check($sformatf("r%0d_sweep_order_errs", r), order_err, 0);
    check($sformatf("r%0d_match", r), d_m, int'(v.exp_m));
    check($sformatf("r%0d_timeout", r), d_t, int'(v.exp_t));
    check($sformatf("r%0d_sync_cnt", r), d_sync, v.exp_sync);
    check($sformatf("r%0d_synced", r), d_synced, (v.exp_sync >= SYNC_TH) ? 1 : 0);
    @(negedge clk);
    check($sformatf("r%0d_idle_after_done", r), int'({bus.busy, bus.done}), 0);
  endtask

  initial begin
    vec_t tbl[9];
    vec_t v;
    bit   found;
    int   lat;
    bit   m, t;

    tbl[0] = '{3,  1'b1, 1'b1, 1'b0, 128, 1'b1, 1'b0, 1};  // T1
    tbl[1] = '{0,  1'b0, 1'b1, 1'b0, 81,  1'b0, 1'b1, 0};  // T2 timeout
    tbl[2] = '{1,  1'b1, 1'b1, 1'b0, 126, 1'b1, 1'b0, 1};  // T3 matched x4
    tbl[3] = '{1,  1'b0, 1'b0, 1'b0, 126, 1'b1, 1'b0, 2};
    tbl[4] = '{4,  1'b1, 1'b1, 1'b0, 129, 1'b1, 1'b0, 3};
    tbl[5] = '{1,  1'b0, 1'b0, 1'b0, 126, 1'b1, 1'b0, 4};
    tbl[6] = '{5,  1'b0, 1'b1, 1'b0, 70,  1'b0, 1'b0, 0};  // T3 mismatch
    tbl[7] = '{16, 1'b1, 1'b1, 1'b0, 141, 1'b1, 1'b0, 1};  // T4 last WAIT_P cycle
    tbl[8] = '{2,  1'b0, 1'b0, 1'b1, 127, 1'b1, 1'b0, 2};  // T5 noise in MAC

    bus.start = 1'b0; bus.tau_valid = 1'b0; bus.tau_ours = 1'b0; bus.tau_part = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_round(i, tbl[i]);
      ref_sync = tbl[i].exp_sync;
    end

    // T6: reset mid-MAC at unit=1, idx=7.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (bus.mac_en && bus.unit == 2'd1 && bus.idx == 5'd7) found = 1;
      else @(negedge clk);
    end
    check("t6_reach_u1_i7", int'(found), 1);
    #2 rst = 1'b1;
    #1 check("t6_async_reset_outputs", all_outputs(), 0);
    @(negedge clk);
    check("t6_reset_held_outputs", all_outputs(), 0);
    rst = 1'b0;
    ref_sync = 0;
    v = '{2, 1'b1, 1'b1, 1'b0, 127, 1'b1, 1'b0, 1};
    run_round(9, v);
    ref_sync = 1;

    // Randomized rounds against the round-level model.
    for (int i = 0; i < 12; i++) begin
      v.vcyc  = $urandom_range(0, TMO + 1);
      v.ours  = 1'($urandom_range(0, 1));
      v.part  = ($urandom_range(0, 3) == 0) ? ~v.ours : v.ours;
      v.noise = 1'($urandom_range(0, 1));
      model_round(v.vcyc, v.ours, v.part, lat, m, t);
      ref_sync   = m ? ((ref_sync < SYNC_SAT) ? ref_sync + 1 : SYNC_SAT) : 0;
      v.exp_lat  = lat;
      v.exp_m    = m;
      v.exp_t    = t;
      v.exp_sync = ref_sync;
      run_round(10 + i, v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
